// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO data controller: window offsets from
// PRAM_ADDR, PRAM status bit positions and a constant clog2 helper.
package mmio_pkg;

    localparam int OFS_PRAM      = 0;
    localparam int OFS_KEY0      = 1;
    localparam int ST_PRAM_FULL  = 0;
    localparam int ST_FIFO_FULL  = 1;
    localparam int ST_FIFO_EMPTY = 2;

    function automatic int ofs_lcd(input int num_keys);
        return OFS_KEY0 + num_keys;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/mmio_post_fifo.sv
// Posting FIFO between CPU PRAM writes and the PRAM queue.
// Push while full and pop while empty are ignored.
module mmio_post_fifo
    import mmio_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PW = clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: reset empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_data_controller.sv
// CPU data-side controller: MMIO window with PRAM posting FIFO, key latches, LCD.
// Optional `define KEY_IRQ_EN adds a key mask register at LCD-1 and key_irq.
module mmio_data_controller
    import mmio_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                NUM_KEYS   = 6,
    parameter logic [ADDR_W-1:0] PRAM_ADDR  = 16'hFFFF,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic                cpu_wr_en,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wr_en,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   pram_data,
    output logic                pram_wr_en,
    input  logic                pram_full,
    input  logic [NUM_KEYS-1:0] key_pulse,
    output logic [DATA_W-1:0]   lcd_data,
`ifdef KEY_IRQ_EN
    output logic                key_irq,
`endif
    output logic                lcd_wr
);

    localparam int OFS_LCD = ofs_lcd(NUM_KEYS);
`ifdef KEY_IRQ_EN
    localparam int OFS_TOP = OFS_LCD + 1;
`else
    localparam int OFS_TOP = OFS_LCD;
`endif

    logic [ADDR_W-1:0]   ofs;
    logic                hit;
    logic                pram_sel;
    logic                lcd_sel;
    logic                key_sel;
    logic [NUM_KEYS-1:0] key_onehot;
    logic [NUM_KEYS-1:0] key_clr;
    logic [NUM_KEYS-1:0] key_latch;
    logic                fifo_full;
    logic                fifo_empty;
    logic                sel_q;
    logic [DATA_W-1:0]   mmio_q;
    logic [DATA_W-1:0]   rd_val;

    // Offset below PRAM_ADDR; addresses above PRAM_ADDR wrap to large values.
    assign ofs      = PRAM_ADDR - cpu_addr;
    assign hit      = (ofs <= ADDR_W'(OFS_TOP));
    assign pram_sel = (ofs == ADDR_W'(OFS_PRAM));
    assign lcd_sel  = (ofs == ADDR_W'(OFS_LCD));

    assign mem_addr   = cpu_addr;
    assign mem_wdata  = cpu_wdata;
    assign mem_wr_en  = cpu_wr_en && !hit;
    assign cpu_stall  = cpu_wr_en && pram_sel && fifo_full;
    assign pram_wr_en = !fifo_empty && !pram_full;
    assign cpu_rdata  = sel_q ? mmio_q : mem_rdata;

    mmio_post_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cpu_wr_en && pram_sel),
        .din     (cpu_wdata),
        .pop     (pram_wr_en),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (pram_data)
    );

    always_comb begin
        key_onehot = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            key_onehot[i] = (ofs == ADDR_W'(OFS_KEY0 + i));
    end

    assign key_sel = |key_onehot;
    assign key_clr = key_onehot & {NUM_KEYS{cpu_wr_en && (|cpu_wdata)}};

`ifdef KEY_IRQ_EN
    logic [NUM_KEYS-1:0] key_mask;
    logic                mask_sel;

    assign mask_sel = (ofs == ADDR_W'(OFS_LCD + 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_mask <= '0;
            key_irq  <= 1'b0;
        end else begin
            if (cpu_wr_en && mask_sel) key_mask <= cpu_wdata[NUM_KEYS-1:0];
            key_irq <= |(key_latch & key_mask);
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            pram_sel: begin
                rd_val[ST_PRAM_FULL]  = pram_full;
                rd_val[ST_FIFO_FULL]  = fifo_full;
                rd_val[ST_FIFO_EMPTY] = fifo_empty;
            end
            key_sel: rd_val[0] = |(key_latch & key_onehot);
            lcd_sel: rd_val = lcd_data;
`ifdef KEY_IRQ_EN
            mask_sel: rd_val[NUM_KEYS-1:0] = key_mask;
`endif
            default: ;
        endcase
    end

    // A pulse wins over a clearing write in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= 1'b0;
            mmio_q    <= '0;
            key_latch <= '0;
            lcd_data  <= '0;
            lcd_wr    <= 1'b0;
        end else begin
            sel_q     <= hit;
            mmio_q    <= rd_val;
            key_latch <= key_pulse | (key_latch & ~key_clr);
            if (cpu_wr_en && lcd_sel) lcd_data <= cpu_wdata;
            lcd_wr    <= cpu_wr_en && lcd_sel;
        end
    end

endmodule
